// File: rtl/risc16_ctrl_pkg.sv
// Shared definitions for the RISC16 multi-cycle controller: state encoding,
// opcode map, ALU class codes and the control-word layout.
package risc16_ctrl_pkg;

    // FSM state encoding (IDLE must stay all-zero so the debug port reads 0 in reset)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;

    // Opcode map
    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_SW  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_INV = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_CLR = 4'd10;
    localparam logic [3:0] OP_BEQ = 4'd11;
    localparam logic [3:0] OP_BNE = 4'd12;
    localparam logic [3:0] OP_JMP = 4'd13;
    localparam logic [3:0] OP_INC = 4'd14;
    localparam logic [3:0] OP_DEC = 4'd15;

    // ALU class codes
    localparam logic [1:0] ALU_RTYPE  = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_ADDR   = 2'b10;

    // Full set of controller outputs except state/retired
    typedef struct packed {
        logic       imem_req;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       jump;
        logic       beq;
        logic       bne;
        logic       inc;
        logic       dec;
        logic       clr;
    } ctrl_t;

    // ADD..SLT form one contiguous block of the opcode space
    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

    // Branches and jumps retire directly out of EXEC
    function automatic logic ends_in_exec(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller takes the
// master side; the datapath (or a bench) takes the slave side.
interface multi_cycle_control_if #(
    parameter int COUNT_W = 16
);
    logic               run;
    logic [3:0]         opcode;
    logic               imem_ready;
    logic               dmem_ready;
    logic               imem_req;
    logic               pc_write;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic [1:0]         alu_op;
    logic               jump;
    logic               beq;
    logic               bne;
    logic               inc;
    logic               dec;
    logic               clr;
    logic [2:0]         state;
    logic [COUNT_W-1:0] retired;

    modport master (
        input  run, opcode, imem_ready, dmem_ready,
        output imem_req, pc_write, ir_write, mem_read, mem_write,
               alu_src, reg_dst, mem_to_reg, reg_write, alu_op,
               jump, beq, bne, inc, dec, clr, state, retired
    );

    modport slave (
        output run, opcode, imem_ready, dmem_ready,
        input  imem_req, pc_write, ir_write, mem_read, mem_write,
               alu_src, reg_dst, mem_to_reg, reg_write, alu_op,
               jump, beq, bne, inc, dec, clr, state, retired
    );
endinterface

// File: rtl/multi_cycle_control_decode.sv
// Combinational control decode: maps the registered FSM state and the IR
// opcode to the datapath control word. Only the FETCH strobes look at a
// ready input, so an instruction fetch completing in its first cycle
// still loads IR/PC that same cycle.
module ctrl_decode
    import risc16_ctrl_pkg::*;
(
    input  logic [2:0] state,
    input  logic [3:0] opcode,
    input  logic       imem_ready,
    output ctrl_t      ctrl
);

    // Decode outputs; everything defaults low so IDLE/DECODE emit nothing
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.imem_req = 1'b1;
                ctrl.ir_write = imem_ready;
                ctrl.pc_write = imem_ready;
            end
            ST_EXEC: begin
                ctrl.alu_src = is_mem_op(opcode);
                if (is_mem_op(opcode)) begin
                    ctrl.alu_op = ALU_ADDR;
                end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
                    ctrl.alu_op = ALU_BRANCH;
                end else begin
                    ctrl.alu_op = ALU_RTYPE;
                end
                ctrl.beq  = (opcode == OP_BEQ);
                ctrl.bne  = (opcode == OP_BNE);
                ctrl.jump = (opcode == OP_JMP);
            end
            ST_MEM: begin
                ctrl.alu_op    = ALU_ADDR;
                ctrl.mem_read  = (opcode == OP_LW);
                ctrl.mem_write = (opcode == OP_SW);
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (opcode == OP_LW);
                ctrl.reg_dst    = is_rtype(opcode) || (opcode == OP_INC) ||
                                  (opcode == OP_DEC) || (opcode == OP_CLR);
                ctrl.inc        = (opcode == OP_INC);
                ctrl.dec        = (opcode == OP_DEC);
                ctrl.clr        = (opcode == OP_CLR);
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle RISC16 controller: instruction sequencing FSM and the
// retired-instruction counter. Control outputs come from ctrl_decode.
module multi_cycle_control
    import risc16_ctrl_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_cycle_control_if.master  bus
);

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic               complete;
    logic [COUNT_W-1:0] retired_q;
    ctrl_t              ctrl;

    ctrl_decode u_decode (
        .state      (state_q),
        .opcode     (bus.opcode),
        .imem_ready (bus.imem_ready),
        .ctrl       (ctrl)
    );

    // Next-state selection; run only matters in IDLE and on completion
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (ends_in_exec(bus.opcode)) begin
                    complete = 1'b1;
                end else if (is_mem_op(bus.opcode)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    if (bus.opcode == OP_SW) complete = 1'b1;
                    else                     state_d  = ST_WB;
                end
            end
            ST_WB:   complete = 1'b1;
            default: state_d  = ST_IDLE;
        endcase
        if (complete) state_d = bus.run ? ST_FETCH : ST_IDLE;
    end

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Retired counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        retired_q <= '0;
        else if (complete) retired_q <= retired_q + COUNT_W'(1);
    end

    assign bus.imem_req   = ctrl.imem_req;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.alu_src    = ctrl.alu_src;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_op     = ctrl.alu_op;
    assign bus.jump       = ctrl.jump;
    assign bus.beq        = ctrl.beq;
    assign bus.bne        = ctrl.bne;
    assign bus.inc        = ctrl.inc;
    assign bus.dec        = ctrl.dec;
    assign bus.clr        = ctrl.clr;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: each instruction is expanded into its
// sequence of phases (fetch waits, decode, exec, memory waits, writeback)
// and every cycle's outputs are compared with the phase/opcode table.
module tb_multi_cycle_control;
    import risc16_ctrl_pkg::*;

    // Narrow counter so the wrap is reachable in a short run
    localparam int CW = 8;

    typedef enum int {PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB} phase_e;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   exp_retired = 0;
    bit   in_fetch = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_control_if #(.COUNT_W(CW)) bus();

    multi_cycle_control #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    // Expected control word {imem_req,pc_write,ir_write,mem_read,mem_write,
    // alu_src,reg_dst,mem_to_reg,reg_write,alu_op[1:0],jump,beq,bne,inc,dec,clr}
    function automatic logic [16:0] expect_vec(phase_e ph, logic [3:0] op, logic irdy);
        logic ireq, pcw, irw, mrd, mwr, asrc, rdst, m2r, rwr, jmp, bq, bn, ic, dc, cl;
        logic [1:0] aop;
        logic lw, sw;
        lw = (op == 4'd0);
        sw = (op == 4'd1);
        {ireq, pcw, irw, mrd, mwr, asrc, rdst, m2r, rwr, jmp, bq, bn, ic, dc, cl} = '0;
        aop = 2'b00;
        case (ph)
            PH_FETCH: begin ireq = 1'b1; pcw = irdy; irw = irdy; end
            PH_EXEC: begin
                asrc = lw | sw;
                aop  = (lw | sw) ? 2'b10 : ((op == 4'd11 || op == 4'd12) ? 2'b01 : 2'b00);
                bq   = (op == 4'd11);
                bn   = (op == 4'd12);
                jmp  = (op == 4'd13);
            end
            PH_MEM: begin aop = 2'b10; mrd = lw; mwr = sw; end
            PH_WB: begin
                rwr  = 1'b1;
                m2r  = lw;
                rdst = (op >= 4'd2 && op <= 4'd10) || op == 4'd14 || op == 4'd15;
                ic   = (op == 4'd14);
                dc   = (op == 4'd15);
                cl   = (op == 4'd10);
            end
            default: ;
        endcase
        return {ireq, pcw, irw, mrd, mwr, asrc, rdst, m2r, rwr, aop, jmp, bq, bn, ic, dc, cl};
    endfunction

    function automatic logic [2:0] expect_state(phase_e ph);
        case (ph)
            PH_FETCH:  return ST_FETCH;
            PH_DECODE: return ST_DECODE;
            PH_EXEC:   return ST_EXEC;
            PH_MEM:    return ST_MEM;
            PH_WB:     return ST_WB;
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic logic [16:0] observed_vec();
        return {bus.imem_req, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.alu_src, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_op,
                bus.jump, bus.beq, bus.bne, bus.inc, bus.dec, bus.clr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, compare at the falling edge
    task automatic step(input phase_e ph, input logic [3:0] op, input logic irdy,
                        input logic drdy, input logic run_v, input string tag);
        bus.imem_ready = irdy;
        bus.dmem_ready = drdy;
        bus.run        = run_v;
        @(negedge clk);
        check({tag, ".ctl"}, 32'(observed_vec()),
              32'(expect_vec(ph, op, (ph == PH_FETCH) ? irdy : 1'b0)));
        check({tag, ".state"}, 32'(bus.state), 32'(expect_state(ph)));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.opcode = 4'($urandom);
            step(PH_IDLE, bus.opcode, rnd(), rnd(), 1'b0, "idle");
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        bus.run  = 1'b1;
        #1;
        check("rst.ctl", 32'(observed_vec()), 32'd0);
        check("rst.state", 32'(bus.state), 32'(ST_IDLE));
        check("rst.retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1;
        check("rst.hold", 32'(observed_vec()), 32'd0);
        bus.run     = 1'b0;
        rst_n       = 1'b1;
        exp_retired = 0;
        in_fetch    = 1'b0;
    endtask

    // Run one instruction starting in FETCH; run_end is the run level at completion
    task automatic do_instr(input logic [3:0] op, input int iwait, input int dwait,
                            input logic run_end);
        bit last;
        if (!in_fetch) begin
            idle(1 + int'($urandom_range(0, 1)));
            step(PH_IDLE, bus.opcode, rnd(), rnd(), 1'b1, "start");
        end
        bus.opcode = op;
        for (int i = 0; i <= iwait; i++)
            step(PH_FETCH, op, (i == iwait), rnd(), rnd(), "fetch");
        step(PH_DECODE, op, rnd(), rnd(), rnd(), "decode");
        if (op == 4'd11 || op == 4'd12 || op == 4'd13) begin
            step(PH_EXEC, op, rnd(), rnd(), run_end, "exec");
        end else begin
            step(PH_EXEC, op, rnd(), rnd(), rnd(), "exec");
            if (op <= 4'd1) begin
                for (int i = 0; i <= dwait; i++) begin
                    last = (i == dwait);
                    step(PH_MEM, op, rnd(), last, (last && op == 4'd1) ? run_end : rnd(), "mem");
                end
            end
            if (op != 4'd1) step(PH_WB, op, rnd(), rnd(), run_end, "wb");
        end
        exp_retired = (exp_retired + 1) % (1 << CW);
        check("retired", 32'(bus.retired), 32'(exp_retired));
        check("next", 32'(bus.state), 32'(run_end ? ST_FETCH : ST_IDLE));
        in_fetch = run_end;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b1;
        bus.run        = 1'b0;
        bus.opcode     = 4'd0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        #2;
        apply_reset();
        idle(3);

        // ADD, LW with three data wait states, SW that drops run at completion
        do_instr(OP_ADD, 0, 0, 1'b1);
        do_instr(OP_LW, 0, 3, 1'b1);
        do_instr(OP_SW, 1, 2, 1'b0);
        idle(2);

        // BEQ then JMP from a fresh reset
        apply_reset();
        do_instr(OP_BEQ, 0, 0, 1'b1);
        do_instr(OP_JMP, 0, 0, 1'b1);
        check("br_jmp.retired", 32'(bus.retired), 32'd2);

        // Random instruction mix with random wait states and run levels
        for (int n = 0; n < 40; n++)
            do_instr(4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) != 0));

        // Reset in the middle of an SW data wait
        if (!in_fetch) begin
            idle(1);
            step(PH_IDLE, bus.opcode, rnd(), rnd(), 1'b1, "start");
        end
        bus.opcode = OP_SW;
        step(PH_FETCH, OP_SW, 1'b1, 1'b0, 1'b1, "fetch");
        step(PH_DECODE, OP_SW, 1'b0, 1'b0, 1'b1, "decode");
        step(PH_EXEC, OP_SW, 1'b0, 1'b0, 1'b1, "exec");
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        check("sw.mem_write", 32'(bus.mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.mem_write", 32'(bus.mem_write), 32'd0);
        check("async.state", 32'(bus.state), 32'(ST_IDLE));
        check("async.retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1;
        check("async.ctl", 32'(observed_vec()), 32'd0);
        rst_n       = 1'b1;
        exp_retired = 0;
        in_fetch    = 1'b0;
        idle(2);

        // INC run through the counter wrap
        for (int n = 0; n < (1 << CW) - 1; n++)
            do_instr(OP_INC, 0, 0, 1'b1);
        check("pre_wrap", 32'(bus.retired), 32'((1 << CW) - 1));
        do_instr(OP_INC, 0, 0, 1'b1);
        check("wrap", 32'(bus.retired), 32'd0);

        // run low at completion parks in IDLE with no fetch request
        do_instr(OP_ADD, 0, 0, 1'b0);
        check("park.imem_req", 32'(bus.imem_req), 32'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
